// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the hazard controller: opcodes, forwarding selects,
// FSM states, the in-flight slot record and the ID decode helper.
package hazard_pkg;

  localparam int RW = 4;
  localparam int OW = 4;

  localparam logic [OW-1:0] OP_AND = 4'b0000;
  localparam logic [OW-1:0] OP_OR  = 4'b0001;
  localparam logic [OW-1:0] OP_ADD = 4'b0010;
  localparam logic [OW-1:0] OP_SUB = 4'b0110;
  localparam logic [OW-1:0] OP_SLT = 4'b0111;
  localparam logic [OW-1:0] OP_LW  = 4'b1000;
  localparam logic [OW-1:0] OP_SW  = 4'b1010;
  localparam logic [OW-1:0] OP_BNE = 4'b1110;
  localparam logic [OW-1:0] OP_JMP = 4'b1111;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_STALL,
    ST_FLUSH
  } state_e;

  typedef struct packed {
    logic          valid;
    logic          regwrite;
    logic          memread;
    logic [RW-1:0] dest;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
  } slot_t;

  // Unused sources are stored as R0 so they can never match a writer.
  function automatic slot_t decode_id(
    input logic          v,
    input logic [OW-1:0] op,
    input logic [RW-1:0] rs,
    input logic [RW-1:0] rt,
    input logic [RW-1:0] rd
  );
    slot_t s;
    logic  rtype;
    logic  lw;
    logic  use_rs;
    logic  use_rt;
    rtype  = (op == OP_ADD) | (op == OP_SUB) | (op == OP_AND)
           | (op == OP_OR)  | (op == OP_SLT);
    lw     = (op == OP_LW);
    use_rt = rtype | (op == OP_SW) | (op == OP_BNE);
    use_rs = use_rt | lw;
    s          = '0;
    s.valid    = v;
    s.regwrite = v & (rtype | lw);
    s.memread  = v & lw;
    s.dest     = s.regwrite ? (lw ? rt : rd) : '0;
    s.rs       = (v & use_rs) ? rs : '0;
    s.rt       = (v & use_rt) ? rt : '0;
    return s;
  endfunction

  function automatic logic writes(input slot_t w, input logic [RW-1:0] r);
    return w.valid & w.regwrite & (w.dest != '0) & (w.dest == r);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ID-side inputs and pipeline control outputs of the hazard controller.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 4,
  parameter int OP_W  = 4,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [OP_W-1:0]  id_opcode;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic [REG_W-1:0] id_rd;
  logic             ex_branch_taken;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_valid, id_opcode, id_rs, id_rt, id_rd, ex_branch_taken,
    input  pc_write, ifid_write, ifid_flush, idex_bubble,
    input  fwd_a, fwd_b, stall_cycles
  );

  modport slave (
    input  id_valid, id_opcode, id_rs, id_rt, id_rd, ex_branch_taken,
    output pc_write, ifid_write, ifid_flush, idex_bubble,
    output fwd_a, fwd_b, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_tracker.sv
// Three-slot in-flight tracker (ID/EX, EX/MEM, MEM/WB) with bubble
// insertion and per-slot source match outputs.
module pipe_slot_tracker
  import hazard_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  slot_t id_i,
  input  logic  bubble_i,
  output logic  hit_ex_o,
  output logic  hit_mem_o,
  output logic  ex_memread_o,
  output logic  rs_mem_o,
  output logic  rs_wb_o,
  output logic  rt_mem_o,
  output logic  rt_wb_o
);

  slot_t ex_q, mem_q, wb_q;
  slot_t ex_d;
  logic  unused_wb;

  assign ex_d = bubble_i ? '0 : id_i;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  assign hit_ex_o  = writes(ex_q, id_i.rs)  | writes(ex_q, id_i.rt);
  assign hit_mem_o = writes(mem_q, id_i.rs) | writes(mem_q, id_i.rt);
  assign ex_memread_o = ex_q.memread;

  assign rs_mem_o = writes(mem_q, ex_q.rs);
  assign rs_wb_o  = writes(wb_q, ex_q.rs);
  assign rt_mem_o = writes(mem_q, ex_q.rt);
  assign rt_wb_o  = writes(wb_q, ex_q.rt);

  assign unused_wb = ^{wb_q.memread, wb_q.rs, wb_q.rt};

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer and EX forwarding selects for the 16-bit core.
// Define HAZARD_FWD_EN to build with operand forwarding.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W = 4,
  parameter int OP_W  = 4,
  parameter int CNT_W = 16
) (
  input logic clock,
  input logic reset,
  pipeline_hazard_ctrl_if.slave hz
);

  state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  slot_t      id_slot;
  logic       id_jmp;
  logic       hit_ex, hit_mem, ex_memread;
  logic       rs_mem, rs_wb, rt_mem, rt_wb;
  logic       hazard, kill, live, stall, jflush, cnt_evt;
  logic       unused_sel;

  assign id_slot = decode_id(hz.id_valid, hz.id_opcode,
                             hz.id_rs, hz.id_rt, hz.id_rd);
  assign id_jmp  = hz.id_valid & (hz.id_opcode == OP_JMP);

  pipe_slot_tracker u_trk (
    .clock        (clock),
    .reset        (reset),
    .id_i         (id_slot),
    .bubble_i     (hz.idex_bubble),
    .hit_ex_o     (hit_ex),
    .hit_mem_o    (hit_mem),
    .ex_memread_o (ex_memread),
    .rs_mem_o     (rs_mem),
    .rs_wb_o      (rs_wb),
    .rt_mem_o     (rt_mem),
    .rt_wb_o      (rt_wb)
  );

`ifdef HAZARD_FWD_EN
  assign hazard   = hit_ex & ex_memread;
  assign hz.fwd_a = rs_mem ? FWD_EXMEM : rs_wb ? FWD_MEMWB : FWD_RF;
  assign hz.fwd_b = rt_mem ? FWD_EXMEM : rt_wb ? FWD_MEMWB : FWD_RF;
  assign unused_sel = hit_mem;
`else
  // MEM/WB writes the register file before ID reads it.
  assign hazard   = hit_ex | hit_mem;
  assign hz.fwd_a = FWD_RF;
  assign hz.fwd_b = FWD_RF;
  assign unused_sel = ^{ex_memread, rs_mem, rs_wb, rt_mem, rt_wb};
`endif

  always_comb begin
    kill   = hz.ex_branch_taken;
    live   = (state_q != ST_FLUSH);
    stall  = ~kill & live & hazard;
    jflush = ~kill & ~stall & live & id_jmp;
    if (state_q == ST_FLUSH) state_d = ST_RUN;
    else if (kill)           state_d = ST_FLUSH;
    else if (stall)          state_d = ST_STALL;
    else if (jflush)         state_d = ST_FLUSH;
    else                     state_d = ST_RUN;
  end

  assign hz.pc_write    = ~stall;
  assign hz.ifid_write  = ~stall;
  assign hz.ifid_flush  = kill | jflush;
  assign hz.idex_bubble = kill | stall;
  assign hz.stall_cycles = cnt_q;
  assign cnt_evt = stall | kill | jflush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (cnt_evt && cnt_q != '1)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed vector bench for pipeline_hazard_ctrl (either HAZARD_FWD_EN build).
module tb_pipeline_hazard_ctrl;

  typedef struct {
    logic       v;
    logic [3:0] op, rs, rt, rd;
    logic       br;
    logic       pw, iw, fl, bb;
    logic [1:0] fa, fb;
    logic [3:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   checks = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_W(4), .OP_W(4), .CNT_W(4)) hz ();

  pipeline_hazard_ctrl #(.REG_W(4), .OP_W(4), .CNT_W(4)) u_dut (
    .clock (clk),
    .reset (rst),
    .hz    (hz)
  );

  function automatic vec_t mk(
    input logic v, input logic [3:0] op, rs, rt, rd, input logic br,
    input logic pw, iw, fl, bb, input logic [1:0] fa, fb,
    input logic [3:0] cnt
  );
    vec_t t;
    t.v = v; t.op = op; t.rs = rs; t.rt = rt; t.rd = rd; t.br = br;
    t.pw = pw; t.iw = iw; t.fl = fl; t.bb = bb;
    t.fa = fa; t.fb = fb; t.cnt = cnt;
    return t;
  endfunction

  task automatic chk(input string nm, input int row,
                     input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s row=%0d got=%0h exp=%0h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, rs, rt, rd,
                       input logic br);
    hz.id_valid = v; hz.id_opcode = op;
    hz.id_rs = rs; hz.id_rt = rt; hz.id_rd = rd;
    hz.ex_branch_taken = br;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
`ifdef HAZARD_FWD_EN
    tbl.push_back(mk(0,0,0,0,0,0, 1,1,0,0,0,0,0));
    tbl.push_back(mk(1,8,1,3,0,0, 1,1,0,0,0,0,0));
    tbl.push_back(mk(1,2,3,2,4,0, 0,0,0,1,0,0,0));
    tbl.push_back(mk(1,2,3,2,4,0, 1,1,0,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0, 1,1,0,0,1,0,1));
    tbl.push_back(mk(1,2,1,2,5,0, 1,1,0,0,0,0,1));
    tbl.push_back(mk(1,6,5,5,6,0, 1,1,0,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0, 1,1,0,0,2,2,1));
    tbl.push_back(mk(1,1,1,2,0,0, 1,1,0,0,0,0,1));
    tbl.push_back(mk(1,0,0,0,7,0, 1,1,0,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0, 1,1,0,0,0,0,1));
    tbl.push_back(mk(1,15,0,0,0,0, 1,1,1,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0, 1,1,0,0,0,0,2));
    tbl.push_back(mk(0,15,0,0,0,0, 1,1,0,0,0,0,2));
    tbl.push_back(mk(1,8,1,3,0,0, 1,1,0,0,0,0,2));
    tbl.push_back(mk(1,2,3,2,4,1, 1,1,1,1,0,0,2));
    tbl.push_back(mk(1,2,3,2,4,0, 1,1,0,0,0,0,3));
    tbl.push_back(mk(0,0,0,0,0,0, 1,1,0,0,1,0,3));
    tbl.push_back(mk(1,8,1,3,0,0, 1,1,0,0,0,0,3));
    tbl.push_back(mk(1,3,3,3,3,0, 1,1,0,0,0,0,3));
`else
    tbl.push_back(mk(0,0,0,0,0,0, 1,1,0,0,0,0,0));
    tbl.push_back(mk(1,8,1,3,0,0, 1,1,0,0,0,0,0));
    tbl.push_back(mk(1,2,3,2,4,0, 0,0,0,1,0,0,0));
    tbl.push_back(mk(1,2,3,2,4,0, 0,0,0,1,0,0,1));
    tbl.push_back(mk(1,2,3,2,4,0, 1,1,0,0,0,0,2));
    tbl.push_back(mk(0,0,0,0,0,0, 1,1,0,0,0,0,2));
    tbl.push_back(mk(1,2,1,2,5,0, 1,1,0,0,0,0,2));
    tbl.push_back(mk(1,6,5,5,6,0, 0,0,0,1,0,0,2));
    tbl.push_back(mk(1,6,5,5,6,0, 0,0,0,1,0,0,3));
    tbl.push_back(mk(1,6,5,5,6,0, 1,1,0,0,0,0,4));
    tbl.push_back(mk(1,1,1,2,0,0, 1,1,0,0,0,0,4));
    tbl.push_back(mk(1,0,0,0,7,0, 1,1,0,0,0,0,4));
    tbl.push_back(mk(1,15,0,0,0,0, 1,1,1,0,0,0,4));
    tbl.push_back(mk(0,0,0,0,0,0, 1,1,0,0,0,0,5));
    tbl.push_back(mk(0,15,0,0,0,0, 1,1,0,0,0,0,5));
    tbl.push_back(mk(1,8,1,3,0,0, 1,1,0,0,0,0,5));
    tbl.push_back(mk(1,2,3,2,4,1, 1,1,1,1,0,0,5));
    tbl.push_back(mk(1,2,3,2,4,0, 1,1,0,0,0,0,6));
    tbl.push_back(mk(0,0,0,0,0,0, 1,1,0,0,0,0,6));
    tbl.push_back(mk(1,8,1,3,0,0, 1,1,0,0,0,0,6));
    tbl.push_back(mk(1,3,3,3,3,0, 1,1,0,0,0,0,6));
`endif

    #2;
    chk("rst_pc_write", -1, 8'(hz.pc_write), 8'd1);
    chk("rst_count", -1, 8'(hz.stall_cycles), 8'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].br);
      #4;
      chk("pc_write", i, 8'(hz.pc_write), 8'(tbl[i].pw));
      chk("ifid_write", i, 8'(hz.ifid_write), 8'(tbl[i].iw));
      chk("ifid_flush", i, 8'(hz.ifid_flush), 8'(tbl[i].fl));
      chk("idex_bubble", i, 8'(hz.idex_bubble), 8'(tbl[i].bb));
      chk("fwd_a", i, 8'(hz.fwd_a), 8'(tbl[i].fa));
      chk("fwd_b", i, 8'(hz.fwd_b), 8'(tbl[i].fb));
      chk("stall_cycles", i, 8'(hz.stall_cycles), 8'(tbl[i].cnt));
      @(posedge clk);
      #1;
    end

    // Reset asserted in the middle of a load-use stall.
    drive(1, 8, 1, 3, 0, 0);
    @(posedge clk);
    #1 drive(1, 2, 3, 2, 4, 0);
    #3 chk("mid_stall_pc_write", 100, 8'(hz.pc_write), 8'd0);
    rst = 1'b1;
    #1;
    chk("rst_async_pc_write", 101, 8'(hz.pc_write), 8'd1);
    chk("rst_async_bubble", 101, 8'(hz.idex_bubble), 8'd0);
    chk("rst_async_count", 101, 8'(hz.stall_cycles), 8'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #3 chk("post_rst_pc_write", 102, 8'(hz.pc_write), 8'd1);
    @(posedge clk);
    #1;

    // Back-to-back branch kills drive the counter into saturation.
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      #3;
      chk("sat_flush", 200 + i, 8'(hz.ifid_flush), 8'd1);
      chk("sat_count", 200 + i, 8'(hz.stall_cycles),
          8'((i > 15) ? 15 : i));
      @(posedge clk);
      #1;
    end
    drive(0, 0, 0, 0, 0, 0);
    #3;
    chk("sat_hold_flush", 300, 8'(hz.ifid_flush), 8'd0);
    chk("sat_hold_count", 300, 8'(hz.stall_cycles), 8'd15);
    @(posedge clk);
    #1;
    chk("sat_hold_count2", 301, 8'(hz.stall_cycles), 8'd15);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 16-bit pipelined RISC core. It sits beside the decode stage and the opcode controller. It tracks the destination registers of in-flight instructions and decides, every cycle, whether to:
- advance the pipeline,
- stall it (insert a bubble), or
- flush it (after a taken BNE or a JMP).

It also drives the ALU operand forwarding selects for the execute stage.

## Interface
Parameters:
- REG_W, 4, register-specifier width (16 registers; R0 reads zero)
- OP_W, 4, opcode width
- CNT_W, 16, stall/flush performance counter width

Ports (reset is asynchronous and active-high):
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  the IF/ID register holds a real instruction
- id_opcode  in  OP_W  opcode of the instruction in ID
- id_rs  in  REG_W  first source field
- id_rt  in  REG_W  second source field; also the destination for LW
- id_rd  in  REG_W  destination for R-type
- ex_branch_taken  in  1  the BNE in EX resolved as taken (same cycle)
- pc_write  out  1  PC may update
- ifid_write  out  1  IF/ID may load
- ifid_flush  out  1  the IF/ID contents become a bubble at the next edge
- idex_bubble  out  1  the ID/EX register loads a NOP
- fwd_a  out  2  EX operand A select: 00 register file, 10 EX/MEM, 01 MEM/WB
- fwd_b  out  2  EX operand B select, same encoding
- stall_cycles  out  CNT_W  count of stall and flush cycles, saturating

## Operation
Decode:
- Writers: ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111 write id_rd; LW 1000 writes id_rt.
- Sources: R-type uses rs and rt; LW uses rs; SW 1010 and BNE 1110 use rs and rt; JMP 1111 uses none.
- Unlisted opcodes are treated as NOPs.

Slot tracker:
- Three slots model ID/EX, EX/MEM and MEM/WB. Each slot holds {valid, regwrite, memread, dest, rs, rt}.
- Every clock, the slots shift: ID→EX, EX→MEM, MEM→WB.
- When idex_bubble=1, the ID/EX slot loads invalid.

Hazard rules:
- Destination R0 never creates a hazard.
- A match requires the slot to be valid, regwrite=1, and dest equal to a used source.

FSM states:
- **RUN**: normal operation.
  - A hazard sets stall=1 and moves to STALL.
  - ex_branch_taken, or a JMP in ID, moves to FLUSH.
- **STALL**: pc_write=0, ifid_write=0, idex_bubble=1.
  - Hazard re-evaluated each cycle.
  - Returns to RUN when the hazard clears.
  - ex_branch_taken overrides and moves to FLUSH.
- **FLUSH**: one cycle, entered after the kill.
  - Hazard checks are suppressed because ID holds a bubble.
  - Always returns to RUN.

Kill actions:
- ex_branch_taken: ifid_flush=1 and idex_bubble=1 in the same cycle (kills the IF and ID instructions).
- JMP in ID: ifid_flush=1 only (kills the one fetched instruction); the JMP itself proceeds.

Priority:
- ex_branch_taken > stall > JMP flush > run.
- A load-use hazard on the same cycle as a taken branch produces a flush, not a stall.

Other rules:
- stall_cycles increments on every cycle with pc_write=0 or ifid_flush=1, and holds at all-ones.
- fwd_a and fwd_b compare the rs and rt of the ID/EX slot against the EX/MEM dest first, then the MEM/WB dest; EX/MEM wins when both match.

## Timing
- All outputs are combinational from the registered slots/FSM and the ID inputs. Zero-cycle decision latency.
- Reset values (asynchronous, immediate):
  - all slots invalid, FSM=RUN
  - pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0
  - fwd_a=fwd_b=00, stall_cycles=0
- Reset mid-stall or mid-flush abandons the operation; the first post-reset cycle is RUN with no hazards.
- With forwarding compiled in, a load-use hazard costs exactly 1 stall cycle.
- With forwarding compiled out, the ID instruction waits until the writer has left EX/MEM: up to 2 stall cycles. MEM/WB is assumed to write the register file first.
- When id_valid=0, ID has no sources, no stall occurs and no JMP flush occurs.

## Configuration
- HAZARD_FWD_EN defined:
  - fwd_a and fwd_b are active.
  - A stall occurs only when the ID/EX slot has memread=1 and its dest matches a used ID source.
- HAZARD_FWD_EN undefined:
  - fwd_a and fwd_b are tied to 00.
  - A stall occurs on any match against the ID/EX or EX/MEM slot.

## Structure
- Shared package hazard_pkg holds:
  - opcode constants OP_ADD…OP_JMP
  - forwarding encodings FWD_RF, FWD_EXMEM, FWD_MEMWB
  - FSM state enum
  - the slot struct typedef
- Sub-module pipe_slot_tracker holds the three-slot shift register with bubble insertion and the per-slot match outputs. The top level holds the FSM, the forwarding muxes and the counter.

## Test plan
- LW R3,0(R1) then ADD R4,R3,R2 back-to-back:
  - forwarding build: pc_write=0 for 1 cycle, then fwd_a=01.
  - no-forwarding build: 2 stall cycles; stall_cycles=1 or 2 respectively.
- ADD R5,R1,R2 then SUB R6,R5,R5 with forwarding: no stall; fwd_a=10 and fwd_b=10 when SUB is in EX.
- ex_branch_taken=1 while a load-use hazard is present: ifid_flush=1 and idex_bubble=1 in the same cycle, FSM goes to FLUSH, then to RUN with no stall.
- JMP in ID with id_valid=1: ifid_flush=1 for one cycle and pc_write stays 1.
- Writer with dest R0 followed by a reader of R0: no stall, fwd_a=00.
- Assert reset during STALL: pc_write=1 and stall_cycles=0 immediately. Force the counter near all-ones and apply continuous stalls: the counter holds at all-ones.
